// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receive path (uart_rx_byte) and the
// upcoming transmit path (uart_tx_byte).
//   UART_CLKS_PER_BIT_115200 : clock cycles per bit for 115200 baud at 100 MHz
//   UART_DATA_BITS           : data bits per 8N1 frame
//   rx_state_t               : receiver FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_CLKS_PER_BIT_115200 = 868;
   localparam int UART_DATA_BITS           = 8;

   // WAIT_IDLE exists so that after reset or a framing error the receiver
   // never locks onto the middle of a frame: it must first see the line idle.
   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Two flip-flop synchroniser for a single asynchronous input. The reset value
// is a parameter so an idle-high serial line can come out of reset reading 1.
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   i_async : asynchronous input
//   o_sync  : synchronised copy of i_async, two clocks of latency
// ----------------------------------------------------------------------------
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic [1:0] r_sync;

   // The first stage may go metastable; only the second stage is used
   // downstream, giving it a full clock period to settle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= {2{RESET_VAL}};
      end else begin
         r_sync <= {r_sync[0], i_async};
      end
   end

   assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver: deserialises the RXD line (LSB first, mid-bit sampling
// from a clock-count timer) and presents each byte on a valid/ready master
// port feeding the PITCH message parser.
// Ports:
//   clk           : system clock, all logic on rising edge
//   reset         : synchronous, active-high reset
//   uart_rxd      : asynchronous serial line, idle high
//   m_axis_tdata  : received byte, bit 0 = first data bit on the line
//   m_axis_tvalid : byte available, held until accepted
//   m_axis_tready : downstream accepts when tvalid & tready
//   frame_err     : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun       : one-cycle pulse, new byte dropped because output was full
// CLKS_PER_BIT must be at least 4 so the half-bit start check is meaningful.
// ----------------------------------------------------------------------------
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF_BIT_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END      = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_BITS - 1);

   rx_state_t            r_state;
   logic [CW-1:0]        r_clkCnt;
   logic [BW-1:0]        r_bitCnt;
   logic [DATA_BITS-1:0] r_shift;

   logic w_rxd;
   logic w_shiftEn;
   logic w_stopSample;
   logic w_stopGood;
   logic w_stopBad;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (uart_rxd),
      .o_sync  (w_rxd)
   );

   assign w_shiftEn    = (r_state == DATA) && (r_clkCnt == BIT_END);
   assign w_stopSample = (r_state == STOP) && (r_clkCnt == BIT_END);
   assign w_stopGood   = w_stopSample &&  w_rxd;
   assign w_stopBad    = w_stopSample && !w_rxd;

   // Frame sequencing and bit timing. START waits half a bit so that every
   // later sample lands mid-bit after one full bit time. STOP returns to IDLE
   // at mid-stop so a start bit that follows immediately is still caught.
   // Counters are cleared at each terminal count, so they never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= WAIT_IDLE;
         r_clkCnt <= '0;
         r_bitCnt <= '0;
      end else begin
         case (r_state)
            WAIT_IDLE: begin
               if (w_rxd) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               if (!w_rxd) begin
                  r_state  <= START;
                  r_clkCnt <= '0;
               end
            end
            START: begin
               if (r_clkCnt == HALF_BIT_END) begin
                  r_clkCnt <= '0;
                  if (!w_rxd) begin
                     r_state  <= DATA;
                     r_bitCnt <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            DATA: begin
               if (r_clkCnt == BIT_END) begin
                  r_clkCnt <= '0;
                  r_bitCnt <= r_bitCnt + 1'b1;
                  if (r_bitCnt == LAST_BIT) begin
                     r_state <= STOP;
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            STOP: begin
               if (r_clkCnt == BIT_END) begin
                  r_clkCnt <= '0;
                  r_state  <= w_rxd ? IDLE : WAIT_IDLE;
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            default: begin
               r_state <= WAIT_IDLE;
            end
         endcase
      end
   end

   // Data bits arrive LSB first, so each sample enters at the MSB and the
   // register shifts right; after the last bit the first one sits in bit 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
      end else if (w_shiftEn) begin
         r_shift <= {w_rxd, r_shift[DATA_BITS-1:1]};
      end
   end

   // Output holding register and status pulses. A byte is loaded when the
   // register is empty or is being emptied in this same cycle; otherwise the
   // new byte is dropped and the held one stays untouched. A good stop and a
   // bad stop are mutually exclusive, so frame_err and overrun never coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_err <= w_stopBad;
         overrun   <= 1'b0;
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (w_stopGood) begin
            if (!m_axis_tvalid || m_axis_tready) begin
               m_axis_tdata  <= r_shift;
               m_axis_tvalid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_byte
// Self-checking bench for uart_rx_byte at CLKS_PER_BIT=16. A behavioural line
// driver serialises bytes into 8N1 frames; a passive monitor records every
// accepted byte and every status pulse; each scenario task compares those
// records against values predicted from the framing and handshake rules.
// ----------------------------------------------------------------------------
module tb_uart_rx_byte;

   localparam int CPB   = 16;
   localparam int DBITS = 8;
   localparam int FRAME = (DBITS + 2) * CPB;
   // Start edge to visible tvalid: 2 synchroniser clocks, 1 clock to notice the
   // edge, half a bit to mid-start, 8 data bits plus the stop bit, measured
   // to the first cycle in which the registered output shows the byte.
   localparam int DELIVER_LAT = 3 + CPB / 2 + (DBITS + 1) * CPB;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             uart_rxd = 1'b1;
   logic             m_axis_tready = 1'b0;
   logic [DBITS-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             frame_err;
   logic             overrun;

   int testsRun  = 0;
   int failCount = 0;

   // Monitor records
   logic [7:0] gotQ[$];
   int         cyc = 0;
   int         frameStartCyc = 0;
   int         validRiseCyc = -1;
   int         ferrPulses = 0;
   int         ferrHigh = 0;
   int         ovrPulses = 0;
   int         ovrHigh = 0;
   int         bothHigh = 0;
   int         stallChanges = 0;
   logic       prevValid = 1'b0;
   logic       prevFerr = 1'b0;
   logic       prevOvr = 1'b0;
   logic       prevStall = 1'b0;
   logic [7:0] prevData = 8'h00;

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DBITS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .uart_rxd      (uart_rxd),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .frame_err     (frame_err),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Passive observer, sampling 1 ns after the falling edge: inputs driven on
   // that edge are what the next rising edge will see, outputs are settled.
   always @(negedge clk) begin
      #1;
      if (m_axis_tvalid && m_axis_tready) gotQ.push_back(m_axis_tdata);
      if (frame_err) ferrHigh++;
      if (frame_err && !prevFerr) ferrPulses++;
      if (overrun) ovrHigh++;
      if (overrun && !prevOvr) ovrPulses++;
      if (frame_err && overrun) bothHigh++;
      if (prevStall && m_axis_tvalid && (m_axis_tdata !== prevData)) stallChanges++;
      if (m_axis_tvalid && !prevValid) validRiseCyc = cyc;
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevValid = m_axis_tvalid;
      prevFerr  = frame_err;
      prevOvr   = overrun;
      cyc++;
   end

   // Safety net in case the simulation stalls.
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearMonitor();
      gotQ.delete();
      validRiseCyc = -1;
      ferrPulses   = 0;
      ferrHigh     = 0;
      ovrPulses    = 0;
      ovrHigh      = 0;
      bothHigh     = 0;
      stallChanges = 0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         uart_rxd = 1'b1;
      end
   endtask

   // Drives the first nCycles of an 8N1 frame: start bit, data LSB first, stop.
   task automatic driveFramePart(input logic [7:0] data, input logic stopBit, input int nCycles);
      for (int i = 0; i < nCycles; i++) begin
         @(negedge clk);
         if (i == 0) frameStartCyc = cyc;
         if (i < CPB) uart_rxd = 1'b0;
         else if (i < (DBITS + 1) * CPB) uart_rxd = data[(i / CPB) - 1];
         else uart_rxd = stopBit;
      end
   endtask

   task automatic driveFrame(input logic [7:0] data, input logic stopBit);
      driveFramePart(data, stopBit, FRAME);
   endtask

   // Outputs at reset values while reset is held.
   task automatic test_reset();
      reset = 1'b1;
      uart_rxd = 1'b1;
      m_axis_tready = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      testsRun++;
      if (m_axis_tvalid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
      testsRun++;
      if (m_axis_tdata !== 8'h00) begin failCount++; $display("[TB] FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
      testsRun++;
      if (frame_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      testsRun++;
      if (overrun !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
      @(negedge clk);
      reset = 1'b0;
      idleCycles(2 * CPB);
   endtask

   // A single byte with the consumer always ready.
   task automatic test_single_byte();
      m_axis_tready = 1'b1;
      clearMonitor();
      driveFrame(8'hA5, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (gotQ.size() != 1) begin failCount++; $display("[TB] FAIL single_count: got %0d bytes expected 1", gotQ.size()); end
      else begin
         testsRun++;
         if (gotQ[0] !== 8'hA5) begin failCount++; $display("[TB] FAIL single_data: got %h expected a5", gotQ[0]); end
      end
      testsRun++;
      if (validRiseCyc - frameStartCyc != DELIVER_LAT) begin
         failCount++;
         $display("[TB] FAIL single_latency: got %0d cycles expected %0d", validRiseCyc - frameStartCyc, DELIVER_LAT);
      end
      testsRun++;
      if (ferrPulses + ovrPulses != 0) begin failCount++; $display("[TB] FAIL single_flags: got %0d pulses expected 0", ferrPulses + ovrPulses); end
   endtask

   // A short low glitch must be rejected and leave the receiver ready.
   task automatic test_glitch();
      logic [7:0] r;
      m_axis_tready = 1'b1;
      clearMonitor();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         uart_rxd = 1'b0;
      end
      idleCycles(3 * CPB);
      testsRun++;
      if (validRiseCyc != -1) begin failCount++; $display("[TB] FAIL glitch_tvalid: got tvalid at cycle %0d expected none", validRiseCyc); end
      testsRun++;
      if (ferrPulses != 0) begin failCount++; $display("[TB] FAIL glitch_frame_err: got %0d pulses expected 0", ferrPulses); end
      r = 8'($urandom);
      driveFrame(r, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (gotQ.size() != 1 || gotQ[0] !== r) begin
         failCount++;
         $display("[TB] FAIL glitch_recover: got %0d bytes (first %h) expected 1 byte %h", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00, r);
      end
   endtask

   // Stop bit low: one frame_err pulse, byte discarded, next frame fine.
   task automatic test_frame_err();
      m_axis_tready = 1'b1;
      clearMonitor();
      driveFrame(8'h3C, 1'b0);
      idleCycles(CPB);
      testsRun++;
      if (ferrPulses != 1) begin failCount++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", ferrPulses); end
      testsRun++;
      if (ferrHigh != 1) begin failCount++; $display("[TB] FAIL ferr_width: got %0d cycles expected 1", ferrHigh); end
      testsRun++;
      if (validRiseCyc != -1 || gotQ.size() != 0) begin failCount++; $display("[TB] FAIL ferr_no_byte: got %0d bytes expected 0", gotQ.size()); end
      driveFrame(8'h55, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (gotQ.size() != 1 || gotQ[0] !== 8'h55) begin
         failCount++;
         $display("[TB] FAIL ferr_recover: got %0d bytes (first %h) expected 1 byte 55", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00);
      end
      testsRun++;
      if (ferrPulses != 1) begin failCount++; $display("[TB] FAIL ferr_after_good: got %0d pulses expected 1", ferrPulses); end
   endtask

   // Consumer stalled: second byte dropped with an overrun pulse.
   task automatic test_overrun();
      m_axis_tready = 1'b0;
      clearMonitor();
      driveFrame(8'h11, 1'b1);
      driveFrame(8'h22, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (ovrPulses != 1 || ovrHigh != 1) begin failCount++; $display("[TB] FAIL ovr_pulse: got %0d pulses %0d cycles expected 1 and 1", ovrPulses, ovrHigh); end
      testsRun++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11) begin
         failCount++;
         $display("[TB] FAIL ovr_held: got tvalid=%b tdata=%h expected 1 and 11", m_axis_tvalid, m_axis_tdata);
      end
      testsRun++;
      if (stallChanges != 0) begin failCount++; $display("[TB] FAIL ovr_stable: got %0d tdata changes under stall expected 0", stallChanges); end
      testsRun++;
      if (bothHigh != 0) begin failCount++; $display("[TB] FAIL ovr_exclusive: got %0d overlap cycles expected 0", bothHigh); end
      @(negedge clk);
      m_axis_tready = 1'b1;
      idleCycles(5);
      testsRun++;
      if (gotQ.size() != 1 || gotQ[0] !== 8'h11) begin
         failCount++;
         $display("[TB] FAIL ovr_accept: got %0d bytes (first %h) expected 1 byte 11", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00);
      end
      testsRun++;
      if (m_axis_tvalid !== 1'b0) begin failCount++; $display("[TB] FAIL ovr_drained: got tvalid=%b expected 0", m_axis_tvalid); end
   endtask

   // Reset in the middle of data bit 3 while the line is low.
   task automatic test_reset_mid();
      logic [7:0] pending;
      logic [7:0] partial;
      m_axis_tready = 1'b0;
      clearMonitor();
      pending = 8'($urandom);
      driveFrame(pending, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pending) begin
         failCount++;
         $display("[TB] FAIL rmid_pending: got tvalid=%b tdata=%h expected 1 and %h", m_axis_tvalid, m_axis_tdata, pending);
      end
      partial = 8'($urandom) & 8'hF7;
      driveFramePart(partial, 1'b1, 4 * CPB + CPB / 2);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      testsRun++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL rmid_outputs: got tvalid=%b tdata=%h ferr=%b ovr=%b expected 0 00 0 0", m_axis_tvalid, m_axis_tdata, frame_err, overrun);
      end
      @(negedge clk);
      reset = 1'b0;
      uart_rxd = 1'b1;
      clearMonitor();
      idleCycles(FRAME);
      testsRun++;
      if (validRiseCyc != -1 || ferrPulses != 0 || ovrPulses != 0) begin
         failCount++;
         $display("[TB] FAIL rmid_quiet: got tvalid rise %0d ferr %0d ovr %0d expected none", validRiseCyc, ferrPulses, ovrPulses);
      end
      m_axis_tready = 1'b1;
      driveFrame(8'h0F, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (gotQ.size() != 1 || gotQ[0] !== 8'h0F) begin
         failCount++;
         $display("[TB] FAIL rmid_next: got %0d bytes (first %h) expected 1 byte 0f", gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 8'h00);
      end
   endtask

   // Frames with no idle gap; then tready pulsed exactly at a delivery.
   task automatic test_back_to_back();
      logic [7:0] a;
      logic [7:0] b;
      m_axis_tready = 1'b1;
      clearMonitor();
      driveFrame(8'h00, 1'b1);
      driveFrame(8'hFF, 1'b1);
      idleCycles(CPB);
      testsRun++;
      if (gotQ.size() != 2) begin failCount++; $display("[TB] FAIL b2b_count: got %0d bytes expected 2", gotQ.size()); end
      else begin
         testsRun++;
         if (gotQ[0] !== 8'h00 || gotQ[1] !== 8'hFF) begin failCount++; $display("[TB] FAIL b2b_data: got %h %h expected 00 ff", gotQ[0], gotQ[1]); end
      end
      testsRun++;
      if (ferrPulses + ovrPulses != 0) begin failCount++; $display("[TB] FAIL b2b_flags: got %0d pulses expected 0", ferrPulses + ovrPulses); end

      m_axis_tready = 1'b0;
      clearMonitor();
      a = 8'($urandom);
      b = 8'($urandom);
      fork
         begin
            driveFrame(a, 1'b1);
            driveFrame(b, 1'b1);
         end
         begin
            repeat (FRAME + DELIVER_LAT) @(negedge clk);
            m_axis_tready = 1'b1;
            @(negedge clk);
            m_axis_tready = 1'b0;
         end
      join
      idleCycles(CPB);
      testsRun++;
      if (ovrPulses != 0) begin failCount++; $display("[TB] FAIL b2b_pulse_overrun: got %0d pulses expected 0", ovrPulses); end
      @(negedge clk);
      m_axis_tready = 1'b1;
      idleCycles(4);
      testsRun++;
      if (gotQ.size() != 2 || gotQ[0] !== a || gotQ[1] !== b) begin
         failCount++;
         $display("[TB] FAIL b2b_pulse_data: got %0d bytes (%h %h) expected 2 bytes %h %h", gotQ.size(),
                  (gotQ.size() > 0) ? gotQ[0] : 8'h00, (gotQ.size() > 1) ? gotQ[1] : 8'h00, a, b);
      end
   endtask

   // Random bytes, random stop bits and gaps against a queue model.
   task automatic test_random();
      logic [7:0] expQ[$];
      int         expErr;
      logic       prevBad;
      logic       bad;
      logic [7:0] data;
      int         gap;
      m_axis_tready = 1'b1;
      clearMonitor();
      expErr  = 0;
      prevBad = 1'b0;
      for (int n = 0; n < 12; n++) begin
         data = 8'($urandom);
         bad  = ($urandom_range(0, 3) == 0);
         gap  = prevBad ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
         idleCycles(gap * CPB);
         driveFrame(data, !bad);
         if (bad) expErr++;
         else expQ.push_back(data);
         prevBad = bad;
      end
      idleCycles(2 * CPB);
      testsRun++;
      if (gotQ.size() != expQ.size()) begin failCount++; $display("[TB] FAIL rand_count: got %0d bytes expected %0d", gotQ.size(), expQ.size()); end
      else begin
         for (int k = 0; k < expQ.size(); k++) begin
            testsRun++;
            if (gotQ[k] !== expQ[k]) begin failCount++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", k, gotQ[k], expQ[k]); end
         end
      end
      testsRun++;
      if (ferrPulses != expErr) begin failCount++; $display("[TB] FAIL rand_frame_err: got %0d pulses expected %0d", ferrPulses, expErr); end
      testsRun++;
      if (ovrPulses != 0 || bothHigh != 0) begin failCount++; $display("[TB] FAIL rand_overrun: got %0d pulses expected 0", ovrPulses); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
